// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-3 receiver.
package spi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam int SPI_CPOL   = 1;
    localparam int SPI_CPHA   = 1;
    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises sclk/sdin into clk through equal-length chains and flags sclk rising edges.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sdin,
    output logic sclk_sync,
    output logic sclk_rise,
    output logic sdin_sync
);

    // Preset to the sclk idle level so leaving reset never produces a false rise.
    localparam logic IDLE_LVL = 1'(SPI_CPOL);

    logic [STAGES-1:0] sclk_ff;
    logic [STAGES-1:0] sdin_ff;
    logic              sclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_ff <= {STAGES{IDLE_LVL}};
            sdin_ff <= {STAGES{IDLE_LVL}};
            sclk_d  <= IDLE_LVL;
        end else begin
            sclk_ff <= {sclk_ff[STAGES-2:0], sclk};
            sdin_ff <= {sdin_ff[STAGES-2:0], sdin};
            sclk_d  <= sclk_ff[STAGES-1];
        end
    end

    assign sclk_sync = sclk_ff[STAGES-1];
    assign sdin_sync = sdin_ff[STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_d;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-3 peripheral receiver: MSB-first deserialiser with valid/ready output and sticky overrun.
// Optional sclk-idle abort of partial frames is enabled by defining SPI_RX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no partial frame, bit_cnt == 0
// RECV  | 1..DATA_W-1 bits of the current frame shifted in
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W         = SPI_DATA_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              sclk_sync;
    logic              sclk_rise;
    logic              sdin_sync;
    logic              timeout;
    logic              frame_done;
    logic              load;
    logic              drop;
    logic              accept;

    spi_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sdin     (sdin),
        .sclk_sync(sclk_sync),
        .sclk_rise(sclk_rise),
        .sdin_sync(sdin_sync)
    );

`ifdef SPI_RX_TIMEOUT_EN
    localparam int               IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt;

    // Saturates at the limit; the abort itself returns the FSM to IDLE, which clears it.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || sclk_rise) begin
            idle_cnt <= '0;
        end else if (sclk_sync && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign timeout = (state == RECV) && !sclk_rise && (idle_cnt == IDLE_MAX);
`else
    logic unused_ok;

    assign timeout   = 1'b0;
    assign unused_ok = sclk_sync ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sclk_rise) state_nxt = RECV;
            end
            RECV: begin
                if (sclk_rise && bit_cnt == LAST) state_nxt = IDLE;
                else if (timeout)                 state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        shift_nxt  = {shift_reg[DATA_W-2:0], sdin_sync};
        frame_done = sclk_rise && (state == RECV) && (bit_cnt == LAST);
        accept     = dout_valid && dout_ready;
        load       = frame_done && (!dout_valid || dout_ready);
        drop       = frame_done && !load;
        busy       = (state == RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (timeout) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (sclk_rise) begin
                shift_reg <= shift_nxt;
                bit_cnt   <= frame_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (load) begin
                dout       <= shift_nxt;
                dout_valid <= 1'b1;
            end else if (accept) begin
                dout_valid <= 1'b0;
            end

            // A fresh overrun outranks a clear in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
